// File: rtl/salsa20_8_iter_core_if.sv
// Block handshake bundle for salsa20_8_iter_core.
//   in_valid/in_ready/in_data    : 512-bit input block, valid/ready handshake
//   out_valid/out_ready/out_data : 512-bit hashed block, valid/ready handshake
// Word i of either data bus sits at bits [32i+31:32i].
// master: the block producer/consumer (drives in_*, out_ready)
// slave : the core
interface salsa20_8_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/salsa20_8_iter_core.sv
// Iterative Salsa20/8 core (scrypt BlockMix).
// One four-quarter-round unit is driven per round; column/row gather and
// scatter permutations select which words feed it. After ROUNDS rounds the
// saved input is added back word-wise (feed-forward). One block in flight.
//
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : salsa20_8_iter_core_if.slave (in/out valid-ready handshakes)
//   busy  : high while rounds or the final add are in progress
//
// Optional build macro SALSA_UNROLL2_EN: two rounds (column then row) per
// cycle, counter advances by 2. Results are bit-identical to the default.
module salsa20_8_iter_core #(
  parameter int ROUNDS = 8,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  salsa20_8_iter_core_if.slave  bus,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;

  // Gather order for unit lanes 0..15 (group g = lanes 4g..4g+3).
  localparam int COL_IDX [16] = '{0, 4, 8, 12, 5, 9, 13, 1, 10, 14, 2, 6, 15, 3, 7, 11};
  localparam int ROW_IDX [16] = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};

`ifdef SALSA_UNROLL2_EN
  localparam logic [CNT_W-1:0] STEP = CNT_W'(2);
`else
  localparam logic [CNT_W-1:0] STEP = CNT_W'(1);
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS) - STEP;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Quarter round on (y0,y1,y2,y3) packed low word first.
  function automatic logic [127:0] quarter(input logic [127:0] y);
    logic [31:0] z0, z1, z2, z3;
    z1 = y[63:32]   ^ rotl(y[31:0] + y[127:96], 7);
    z2 = y[95:64]   ^ rotl(z1 + y[31:0], 9);
    z3 = y[127:96]  ^ rotl(z2 + z1, 13);
    z0 = y[31:0]    ^ rotl(z3 + z2, 18);
    return {z3, z2, z1, z0};
  endfunction

  // Four independent quarter rounds on contiguous lane groups.
  function automatic logic [511:0] quad(input logic [511:0] g);
    logic [511:0] q;
    for (int k = 0; k < 4; k++) q[128*k +: 128] = quarter(g[128*k +: 128]);
    return q;
  endfunction

  // One round: gather words into lanes, run the unit, scatter back.
  function automatic logic [511:0] round_fn(input logic [511:0] v, input logic row);
    logic [511:0] g, q, r;
    int idx;
    g = '0;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      idx = row ? ROW_IDX[j] : COL_IDX[j];
      g[32*j +: 32] = v[32*idx +: 32];
    end
    q = quad(g);
    for (int j = 0; j < 16; j++) begin
      idx = row ? ROW_IDX[j] : COL_IDX[j];
      r[32*idx +: 32] = q[32*j +: 32];
    end
    return r;
  endfunction

  state_t           state;
  logic [511:0]     x;
  logic [511:0]     b;
  logic [CNT_W-1:0] cnt;
  logic             acc_ready;
  logic             res_valid;
  logic [511:0]     res_data;
  logic [511:0]     x_step;
  logic [511:0]     sum;

  always_comb begin
    x_step = '0;
`ifdef SALSA_UNROLL2_EN
    x_step = round_fn(round_fn(x, 1'b0), 1'b1);
`else
    // Even counter: column round; odd counter: row round.
    x_step = round_fn(x, cnt[0]);
`endif
  end

  // Feed-forward add, independent mod 2^32 per word.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_add
      assign sum[32*gi +: 32] = x[32*gi +: 32] + b[32*gi +: 32];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      b         <= '0;
      cnt       <= '0;
      acc_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x         <= bus.in_data;
            b         <= bus.in_data;
            cnt       <= '0;
            acc_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ROUND;
          end
        end
        ROUND: begin
          x   <= x_step;
          cnt <= cnt + STEP;
          if (cnt == LAST) state <= ADD;
        end
        ADD: begin
          res_data  <= sum;
          res_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            res_valid <= 1'b0;
            acc_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = acc_ready;
  assign bus.out_valid = res_valid;
  assign bus.out_data  = res_data;

endmodule
